// File: rtl/lut_divider_pkg.sv
// Shared definitions for the reciprocal-LUT divider: widths, the largest
// divisor with a valid LUT entry, and the FSM state encoding.
package lut_divider_pkg;

  localparam int N_W  = 16;
  localparam int D_W  = 9;
  localparam int FRAC = 16;
  localparam logic [D_W-1:0] D_MAX = 9'd169;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MULT,
    S_CORR1,
    S_CORR2,
    S_DONE
  } state_t;

  // Divisors the LUT cannot serve take the error path.
  function automatic logic is_bad_den(input logic [D_W-1:0] d);
    return (d == '0) || (d > D_MAX);
  endfunction

endpackage

// File: rtl/lut_divider.sv
// Sequential unsigned divider: Q = N / D, R = N % D from an external
// reciprocal LUT floor((2^16-1)/D), a multiply, >>16 and two correction steps.
module lut_divider
  import lut_divider_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic [D_W-1:0] lut_sel,
  input  logic [16:0]    lut_recip,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quot,
  output logic [D_W-1:0] rem,
  output logic           div_err
);

  state_t         state, state_n;
  logic [N_W-1:0] num_r;
  logic [D_W-1:0] den_r;
  logic [15:0]    recip;
  logic [N_W-1:0] q;
  logic [16:0]    r;
  logic           err_r;

  logic [31:0]    prod;
  logic [31:0]    qd;
  logic [N_W-1:0] q_est;
  logic [16:0]    r_est;
  logic [16:0]    den_ext;
  logic           r_ge_d;

  // The estimate never overshoots, so N - q*D stays non-negative in 17 bits.
  assign prod    = {16'd0, num_r} * {16'd0, recip};
  assign q_est   = prod[31:FRAC];
  assign qd      = {16'd0, q_est} * {23'd0, den_r};
  assign r_est   = {1'b0, num_r} - qd[16:0];
  assign den_ext = {8'd0, den_r};
  assign r_ge_d  = (r >= den_ext);

  logic unused_bits;
  assign unused_bits = ^{lut_recip[16], prod[FRAC-1:0], qd[31:17]};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign quot      = q;
  assign rem       = r[D_W-1:0];
  assign div_err   = err_r;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (in_valid) state_n = is_bad_den(den) ? S_DONE : S_LOOKUP;
      S_LOOKUP: state_n = S_MULT;
      S_MULT:   state_n = S_CORR1;
      S_CORR1:  state_n = S_CORR2;
      S_CORR2:  state_n = S_DONE;
      S_DONE:   if (out_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      num_r   <= '0;
      den_r   <= '0;
      lut_sel <= '0;
      recip   <= '0;
      q       <= '0;
      r       <= '0;
      err_r   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            num_r   <= num;
            den_r   <= den;
            lut_sel <= den;
            err_r   <= is_bad_den(den);
            recip   <= '0;
            q       <= '0;
            r       <= '0;
          end
        end
        S_LOOKUP: recip <= lut_recip[15:0];
        S_MULT: begin
          q <= q_est;
          r <= r_est;
        end
        S_CORR1, S_CORR2: begin
          if (r_ge_d) begin
            q <= q + 16'd1;
            r <= r - den_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_divider.sv
// Directed self-checking bench for lut_divider with a behavioural model of
// the external reciprocal LUT.
module tb_lut_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] num;
  logic [8:0]  den;
  logic [8:0]  lut_sel;
  logic [16:0] lut_recip;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        div_err;

  int n_cmp  = 0;
  int n_fail = 0;

  lut_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .lut_sel   (lut_sel),
    .lut_recip (lut_recip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  // Bit 16 is set on every entry; the divider must ignore it.
  always_comb begin
    lut_recip = 17'h1FFFF;
    if (lut_sel != 9'd0 && lut_sel <= 9'd169)
      lut_recip = {1'b1, 16'(32'd65535 / {23'd0, lut_sel})};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quot"},      32'(quot),      32'd0);
    check({tag, "_rem"},       32'(rem),       32'd0);
    check({tag, "_div_err"},   32'(div_err),   32'd0);
    check({tag, "_lut_sel"},   32'(lut_sel),   32'd0);
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send(input logic [15:0] n, input logic [8:0] d);
    int tries;
    @(negedge clk);
    num = n;
    den = d;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    check("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid is seen, then check.
  task automatic wait_result(input string tag, input logic [8:0] d,
                             input logic [15:0] eq, input logic [8:0] er,
                             input logic ee, input int elat);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat),      32'(elat));
    check({tag, "_quot"},    32'(quot),     32'(eq));
    check({tag, "_rem"},     32'(rem),      32'(er));
    check({tag, "_div_err"}, 32'(div_err),  32'(ee));
    check({tag, "_lut_sel"}, 32'(lut_sel),  32'(d));
    check({tag, "_busy"},    32'(in_ready), 32'd0);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] n, input logic [8:0] d,
                     input logic [15:0] eq, input logic [8:0] er,
                     input logic ee, input int elat);
    send(n, d);
    wait_result(tag, d, eq, er, ee, elat);
    ack(tag);
  endtask

  initial begin
    logic [15:0] rn;
    logic [8:0]  rd;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num       = '0;
    den       = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run("n640_d20",    16'd640,   9'd20,  16'd32,    9'd0,   1'b0, 5);
    run("n65535_d1",   16'd65535, 9'd1,   16'd65535, 9'd0,   1'b0, 5);
    run("n0_d7",       16'd0,     9'd7,   16'd0,     9'd0,   1'b0, 5);
    run("n65535_d169", 16'd65535, 9'd169, 16'd387,   9'd132, 1'b0, 5);
    run("err_d0",      16'd1234,  9'd0,   16'd0,     9'd0,   1'b1, 1);
    run("err_d170",    16'd5000,  9'd170, 16'd0,     9'd0,   1'b1, 1);
    run("after_err",   16'd100,   9'd3,   16'd33,    9'd1,   1'b0, 5);

    // Consumer ready before the result appears: one-cycle handshake.
    out_ready = 1'b1;
    run("n1000_d169",  16'd1000,  9'd169, 16'd5,     9'd155, 1'b0, 5);

    // Stall in DONE with a new request pending; it must be held off.
    send(16'd500, 9'd13);
    wait_result("stall", 9'd13, 16'd38, 9'd6, 1'b0, 5);
    num = 16'd50;
    den = 9'd5;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_in_ready",  32'(in_ready),  32'd0);
    check("stall_quot",      32'(quot),      32'd38);
    check("stall_rem",       32'(rem),       32'd6);
    ack("stall");
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("after_stall", 9'd5, 16'd10, 9'd0, 1'b0, 5);
    ack("after_stall");

    // Reset while in MULT aborts the request.
    send(16'd1234, 9'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("n99_d9",      16'd99,    9'd9,   16'd11,    9'd0,   1'b0, 5);

    for (int i = 0; i < 24; i++) begin
      rn = 16'($urandom_range(0, 65535));
      rd = 9'($urandom_range(1, 169));
      run("sweep", rn, rd, rn / 16'(rd), 9'(rn % 16'(rd)), 1'b0, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
